// File: rtl/ibuf_rd_sched_if.sv
// Handshake bundle between the input-buffer read scheduler and its job source / read stage.
// The master modport is the scheduler side; the slave modport is the job source / read-stage side.
interface ibuf_rd_sched_if #(
  parameter int OSRW = 4,
  parameter int JOBW = 16
);
  logic [2:0]      cfg_max_rd_req_size;
  logic [63:0]     job_addr;
  logic [JOBW-1:0] job_qw;
  logic            job_valid;
  logic            job_ack;
  logic            job_done;
  logic [63:0]     hst_addr;
  logic [8:0]      rd_qw;
  logic            rd;
  logic            rd_ack;
  logic [OSRW-1:0] rd_tag;
  logic            tag_done;
  logic [OSRW-1:0] tag_done_id;
  logic [OSRW-1:0] tag_lkp;
  logic [8:0]      tag_lkp_qw;
  logic [OSRW:0]   outstanding;
  logic            err;

  modport master (
    input  cfg_max_rd_req_size, job_addr, job_qw, job_valid,
    input  rd_ack, rd_tag, tag_done, tag_done_id, tag_lkp,
    output job_ack, job_done, hst_addr, rd_qw, rd, tag_lkp_qw, outstanding, err
  );

  modport slave (
    output cfg_max_rd_req_size, job_addr, job_qw, job_valid,
    output rd_ack, rd_tag, tag_done, tag_done_id, tag_lkp,
    input  job_ack, job_done, hst_addr, rd_qw, rd, tag_lkp_qw, outstanding, err
  );
endinterface

// File: rtl/ibuf_rd_sched.sv
// Splits host jobs into MRRS-sized read chunks and tracks outstanding read tags.
// Define IBUF_RD_4K_SPLIT_EN to also stop each chunk at the next 4KB host boundary.
module ibuf_rd_sched #(
  parameter int OSRW = 4,
  parameter int JOBW = 16
) (
  input  logic           clk,
  input  logic           rst,
  ibuf_rd_sched_if.master bus
);

  localparam int NTAG = 1 << OSRW;
  localparam int CW   = (JOBW > 10) ? JOBW : 10;

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_REQ, S_NEXT, S_DRAIN} state_t;

  state_t          state, state_nxt;
  logic [63:0]     cur_addr;
  logic [JOBW-1:0] remain;
  logic [JOBW-1:0] remain_nxt;
  logic [63:0]     hst_addr_q;
  logic [8:0]      rd_qw_q;
  logic [8:0]      lim_qw;
  logic [8:0]      chunk_qw;
  logic [8:0]      tag_len [NTAG];
  logic [8:0]      tag_lkp_qw_q;
  logic [NTAG-1:0] busy, busy_nxt;
  logic [OSRW:0]   outstanding_q, outstanding_nxt;
  logic            err_q, err_set;
  logic            rd_int, ack_ok, done_ok;
  logic            job_ack_c, job_done_c;

  function automatic logic [8:0] mrrs_qw(input logic [2:0] code);
    case (code)
      3'd0:    return 9'd16;
      3'd1:    return 9'd32;
      3'd2:    return 9'd64;
      3'd3:    return 9'd128;
      default: return 9'd256;
    endcase
  endfunction

  // Saturate the remaining job length against a chunk limit of at most 256 QW.
  function automatic logic [8:0] clamp_qw(input logic [JOBW-1:0] rem, input logic [8:0] lim);
    if (CW'(rem) < CW'(lim)) return rem[8:0];
    else                     return lim;
  endfunction

`ifdef IBUF_RD_4K_SPLIT_EN
  logic [9:0] bound_qw;
  assign bound_qw = 10'd512 - 10'(cur_addr[11:3]);
  assign lim_qw   = (bound_qw < 10'(mrrs_qw(bus.cfg_max_rd_req_size))) ?
                    bound_qw[8:0] : mrrs_qw(bus.cfg_max_rd_req_size);
`else
  assign lim_qw   = mrrs_qw(bus.cfg_max_rd_req_size);
`endif

  assign chunk_qw   = clamp_qw(remain, lim_qw);
  assign remain_nxt = remain - JOBW'(rd_qw_q);

  // The request is withheld whenever every tag is in flight.
  assign rd_int  = (state == S_REQ) && !outstanding_q[OSRW];
  assign ack_ok  = bus.rd_ack && rd_int;
  assign done_ok = bus.tag_done && (outstanding_q != '0);

  always_comb begin
    state_nxt  = state;
    job_ack_c  = 1'b0;
    job_done_c = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.job_valid) begin
          job_ack_c = 1'b1;
          state_nxt = S_CALC;
        end
      end
      S_CALC:  state_nxt = S_REQ;
      S_REQ:   if (ack_ok) state_nxt = S_NEXT;
      S_NEXT:  state_nxt = (remain_nxt != '0) ? S_CALC : S_DRAIN;
      S_DRAIN: begin
        if (outstanding_q == '0) begin
          job_done_c = 1'b1;
          state_nxt  = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    outstanding_nxt = outstanding_q;
    if (ack_ok && !done_ok)      outstanding_nxt = outstanding_q + {{OSRW{1'b0}}, 1'b1};
    else if (!ack_ok && done_ok) outstanding_nxt = outstanding_q - {{OSRW{1'b0}}, 1'b1};

    busy_nxt = busy;
    if (bus.tag_done) busy_nxt[bus.tag_done_id] = 1'b0;
    if (ack_ok)       busy_nxt[bus.rd_tag]      = 1'b1;

    err_set = (bus.rd_ack && !rd_int)
           || (ack_ok && busy[bus.rd_tag])
           || (bus.tag_done && !busy[bus.tag_done_id])
           || (bus.tag_done && (outstanding_q == '0));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hst_addr_q    <= '0;
      rd_qw_q       <= '0;
      tag_lkp_qw_q  <= '0;
      outstanding_q <= '0;
      busy          <= '0;
      err_q         <= 1'b0;
    end else begin
      if (state == S_CALC) begin
        hst_addr_q <= cur_addr;
        rd_qw_q    <= chunk_qw;
      end
      tag_lkp_qw_q  <= tag_len[bus.tag_lkp];
      outstanding_q <= outstanding_nxt;
      busy          <= busy_nxt;
      err_q         <= err_q | err_set;
    end
  end

  // Job cursor and tag length table carry no reset; they are rewritten before use.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && bus.job_valid) begin
      cur_addr <= bus.job_addr;
      remain   <= bus.job_qw;
    end else if (state == S_NEXT) begin
      cur_addr <= cur_addr + 64'({rd_qw_q, 3'b000});
      remain   <= remain_nxt;
    end
    if (ack_ok) tag_len[bus.rd_tag] <= rd_qw_q;
  end

  assign bus.job_ack     = job_ack_c && !rst;
  assign bus.job_done    = job_done_c;
  assign bus.hst_addr    = hst_addr_q;
  assign bus.rd_qw       = rd_qw_q;
  assign bus.rd          = rd_int;
  assign bus.tag_lkp_qw  = tag_lkp_qw_q;
  assign bus.outstanding = outstanding_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_ibuf_rd_sched.sv
// Directed bench for ibuf_rd_sched with four read tags (OSRW=2).
module tb_ibuf_rd_sched;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  ibuf_rd_sched_if #(.OSRW(2), .JOBW(16)) bus ();

  ibuf_rd_sched #(.OSRW(2), .JOBW(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_job(input logic [63:0] a, input logic [15:0] q);
    bus.job_addr  = a;
    bus.job_qw    = q;
    bus.job_valid = 1'b1;
    #1;
    chk("job_ack_idle", 64'(bus.job_ack), 64'd1);
    cyc();
    bus.job_valid = 1'b0;
    #1;
    chk("job_ack_calc", 64'(bus.job_ack), 64'd0);
    chk("rd_calc", 64'(bus.rd), 64'd0);
    cyc();
  endtask

  task automatic req_ack(input logic [1:0] tag, input logic [63:0] a, input logic [8:0] q,
                         input logic td_en, input logic [1:0] td_id);
    #1;
    chk("rd_req", 64'(bus.rd), 64'd1);
    chk("hst_addr", bus.hst_addr, a);
    chk("rd_qw", 64'(bus.rd_qw), 64'(q));
    bus.rd_ack      = 1'b1;
    bus.rd_tag      = tag;
    bus.tag_done    = td_en;
    bus.tag_done_id = td_id;
    cyc();
    bus.rd_ack   = 1'b0;
    bus.tag_done = 1'b0;
    #1;
    chk("rd_after_ack", 64'(bus.rd), 64'd0);
    cyc();
    cyc();
  endtask

  task automatic td(input logic [1:0] id);
    bus.tag_done    = 1'b1;
    bus.tag_done_id = id;
    cyc();
    bus.tag_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst                     = 1'b1;
    bus.cfg_max_rd_req_size = 3'd2;
    bus.job_addr            = '0;
    bus.job_qw              = '0;
    bus.job_valid           = 1'b1;
    bus.rd_ack              = 1'b0;
    bus.rd_tag              = '0;
    bus.tag_done            = 1'b0;
    bus.tag_done_id         = '0;
    bus.tag_lkp             = '0;
    cyc();
    cyc();
    #1;
    chk("rst_rd", 64'(bus.rd), 64'd0);
    chk("rst_job_ack", 64'(bus.job_ack), 64'd0);
    chk("rst_job_done", 64'(bus.job_done), 64'd0);
    chk("rst_err", 64'(bus.err), 64'd0);
    chk("rst_outstanding", 64'(bus.outstanding), 64'd0);
    chk("rst_hst_addr", bus.hst_addr, 64'd0);
    chk("rst_rd_qw", 64'(bus.rd_qw), 64'd0);
    chk("rst_tag_lkp_qw", 64'(bus.tag_lkp_qw), 64'd0);
    bus.job_valid = 1'b0;
    rst = 1'b0;
    cyc();

    // MRRS 64 QW, 160 QW job: 64, 64, 32
    start_job(64'h1000, 16'd160);
    req_ack(2'd0, 64'h1000, 9'd64, 1'b0, 2'd0);
    req_ack(2'd1, 64'h1200, 9'd64, 1'b0, 2'd0);
    req_ack(2'd2, 64'h1400, 9'd32, 1'b0, 2'd0);
    #1;
    chk("a_outstanding", 64'(bus.outstanding), 64'd3);
    chk("a_done_early", 64'(bus.job_done), 64'd0);
    bus.tag_lkp = 2'd1;
    cyc();
    #1;
    chk("a_lkp1", 64'(bus.tag_lkp_qw), 64'd64);
    bus.tag_lkp = 2'd2;
    cyc();
    #1;
    chk("a_lkp2", 64'(bus.tag_lkp_qw), 64'd32);
    td(2'd0);
    td(2'd1);
    td(2'd2);
    #1;
    chk("a_job_done", 64'(bus.job_done), 64'd1);
    chk("a_outstanding_0", 64'(bus.outstanding), 64'd0);
    chk("a_err", 64'(bus.err), 64'd0);
    cyc();
    #1;
    chk("a_job_done_pulse", 64'(bus.job_done), 64'd0);

    // Simultaneous ack and tag_done with three outstanding
    bus.cfg_max_rd_req_size = 3'd0;
    start_job(64'h2000, 16'd64);
    req_ack(2'd0, 64'h2000, 9'd16, 1'b0, 2'd0);
    req_ack(2'd1, 64'h2080, 9'd16, 1'b0, 2'd0);
    req_ack(2'd2, 64'h2100, 9'd16, 1'b0, 2'd0);
    #1;
    chk("b_outstanding_3", 64'(bus.outstanding), 64'd3);
    req_ack(2'd3, 64'h2180, 9'd16, 1'b1, 2'd0);
    #1;
    chk("b_outstanding_same", 64'(bus.outstanding), 64'd3);
    chk("b_err", 64'(bus.err), 64'd0);
    td(2'd1);
    td(2'd2);
    td(2'd3);
    #1;
    chk("b_job_done", 64'(bus.job_done), 64'd1);
    cyc();

    // Tag exhaustion: four in flight stalls the fifth request
    start_job(64'h3000, 16'd96);
    req_ack(2'd0, 64'h3000, 9'd16, 1'b0, 2'd0);
    req_ack(2'd1, 64'h3080, 9'd16, 1'b0, 2'd0);
    req_ack(2'd2, 64'h3100, 9'd16, 1'b0, 2'd0);
    req_ack(2'd3, 64'h3180, 9'd16, 1'b0, 2'd0);
    #1;
    chk("c_rd_full", 64'(bus.rd), 64'd0);
    chk("c_outstanding_4", 64'(bus.outstanding), 64'd4);
    cyc();
    cyc();
    #1;
    chk("c_rd_held", 64'(bus.rd), 64'd0);
    chk("c_hst_addr_held", bus.hst_addr, 64'h3200);
    td(2'd0);
    req_ack(2'd0, 64'h3200, 9'd16, 1'b0, 2'd0);
    #1;
    chk("c_rd_full2", 64'(bus.rd), 64'd0);
    bus.rd_ack = 1'b1;
    bus.rd_tag = 2'd1;
    cyc();
    bus.rd_ack = 1'b0;
    #1;
    chk("c_err_stray_ack", 64'(bus.err), 64'd1);
    chk("c_outstanding_kept", 64'(bus.outstanding), 64'd4);
    rst = 1'b1;
    #1;
    chk("c_rst_err", 64'(bus.err), 64'd0);
    chk("c_rst_outstanding", 64'(bus.outstanding), 64'd0);
    cyc();
    rst = 1'b0;
    cyc();

    // Duplicate ack on a busy tag, then reset during S_REQ with two outstanding
    start_job(64'h4000, 16'd48);
    req_ack(2'd1, 64'h4000, 9'd16, 1'b0, 2'd0);
    #1;
    chk("d_err_clean", 64'(bus.err), 64'd0);
    req_ack(2'd1, 64'h4080, 9'd16, 1'b0, 2'd0);
    #1;
    chk("d_err_dup", 64'(bus.err), 64'd1);
    chk("d_outstanding_2", 64'(bus.outstanding), 64'd2);
    chk("d_rd_req", 64'(bus.rd), 64'd1);
    rst = 1'b1;
    #1;
    chk("d_rst_rd", 64'(bus.rd), 64'd0);
    chk("d_rst_outstanding", 64'(bus.outstanding), 64'd0);
    chk("d_rst_hst_addr", bus.hst_addr, 64'd0);
    cyc();
    rst = 1'b0;
    cyc();

    // tag_done with nothing outstanding
    #1;
    bus.tag_done    = 1'b1;
    bus.tag_done_id = 2'd0;
    cyc();
    bus.tag_done = 1'b0;
    #1;
    chk("e_err_underflow", 64'(bus.err), 64'd1);
    chk("e_outstanding_0", 64'(bus.outstanding), 64'd0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();

    // Clean restart; MRRS change mid-request and job_valid outside S_IDLE
    bus.cfg_max_rd_req_size = 3'd1;
    start_job(64'h5000, 16'd64);
    #1;
    chk("f_rd_first", 64'(bus.rd), 64'd1);
    chk("f_rd_qw_first", 64'(bus.rd_qw), 64'd32);
    bus.cfg_max_rd_req_size = 3'd0;
    bus.job_valid = 1'b1;
    #1;
    chk("f_job_ack_busy", 64'(bus.job_ack), 64'd0);
    cyc();
    bus.job_valid = 1'b0;
    #1;
    chk("f_rd_qw_stable", 64'(bus.rd_qw), 64'd32);
    chk("f_hst_addr_stable", bus.hst_addr, 64'h5000);
    req_ack(2'd0, 64'h5000, 9'd32, 1'b0, 2'd0);
    req_ack(2'd1, 64'h5100, 9'd16, 1'b0, 2'd0);
    req_ack(2'd2, 64'h5180, 9'd16, 1'b0, 2'd0);
    td(2'd0);
    td(2'd1);
    td(2'd2);
    #1;
    chk("f_job_done", 64'(bus.job_done), 64'd1);
    chk("f_err", 64'(bus.err), 64'd0);
    cyc();

    // Job straddling a 4KB boundary with MRRS 256 QW
    bus.cfg_max_rd_req_size = 3'd4;
    start_job(64'h1F80, 16'd100);
`ifdef IBUF_RD_4K_SPLIT_EN
    req_ack(2'd0, 64'h1F80, 9'd16, 1'b0, 2'd0);
    req_ack(2'd1, 64'h2000, 9'd84, 1'b0, 2'd0);
    td(2'd0);
    td(2'd1);
`else
    req_ack(2'd0, 64'h1F80, 9'd100, 1'b0, 2'd0);
    td(2'd0);
`endif
    #1;
    chk("g_job_done", 64'(bus.job_done), 64'd1);
    chk("g_err", 64'(bus.err), 64'd0);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ibuf_rd_sched.md
IBUF_RD_SCHED -- requirements
Module: ibuf_rd_sched

Interface
REQ-001 SHALL have parameter OSRW, default 4, meaning the read-tag width; the maximum outstanding read count is 2^OSRW.
REQ-002 SHALL have parameter JOBW, default 16, meaning the job length width in QW.
REQ-003 SHALL have port clk  in  1  sole clock; all flops on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port cfg_max_rd_req_size  in  3  PCIe MRRS code: 0=16QW, 1=32, 2=64, 3=128, 4 and above=256.
REQ-006 SHALL have port job_addr  in  64  host byte address of the job, QW aligned.
REQ-007 SHALL have port job_qw  in  JOBW  job length in QW; 0 is illegal.
REQ-008 SHALL have port job_valid  in  1  a job is presented.
REQ-009 SHALL have port job_ack  out  1  one-cycle pulse: job accepted.
REQ-010 SHALL have port job_done  out  1  one-cycle pulse: all chunks issued and all completions returned.
REQ-011 SHALL have port hst_addr  out  64  chunk host address.
REQ-012 SHALL have port rd_qw  out  9  chunk length in QW.
REQ-013 SHALL have port rd  out  1  chunk read request.
REQ-014 SHALL have port rd_ack  in  1  one-cycle pulse: the read stage has taken the request.
REQ-015 SHALL have port rd_tag  in  OSRW  tag of the acked request; valid in the rd_ack cycle.
REQ-016 SHALL have port tag_done  in  1  one-cycle pulse: all data for tag_done_id has been received.
REQ-017 SHALL have port tag_done_id  in  OSRW  tag that completed.
REQ-018 SHALL have port tag_lkp  in  OSRW  tag length lookup index.
REQ-019 SHALL have port tag_lkp_qw  out  9  registered length stored for tag_lkp.
REQ-020 SHALL have port outstanding  out  OSRW+1  count of acked, not-done reads.
REQ-021 SHALL have port err  out  1  sticky protocol error flag.

Function
REQ-022 SHALL implement the FSM S_IDLE, S_CALC, S_REQ, S_NEXT, S_DRAIN.
REQ-023 In S_IDLE with job_valid=1, the block SHALL pulse job_ack, latch the address into cur_addr and the length into remain, and go to S_CALC.
REQ-024 S_CALC SHALL set rd_qw to min(remain, MRRS QW, QW to the next 4KB boundary) and hst_addr to cur_addr, then go to S_REQ.
REQ-025 The QW to the 4KB boundary SHALL be computed as 512 - cur_addr[11:3].
REQ-026 In S_REQ, rd SHALL be 1 only while outstanding < 2^OSRW; otherwise rd SHALL be held at 0 and the state held.
REQ-027 While rd=1, hst_addr and rd_qw SHALL be stable.
REQ-028 On the edge sampling rd_ack=1, rd SHALL go to 0 and the state SHALL go to S_NEXT.
REQ-029 rd_ack arriving while rd=0 SHALL set err and be otherwise ignored.
REQ-030 S_NEXT SHALL update cur_addr += rd_qw*8 and remain -= rd_qw, then go to S_CALC if remain != 0, else S_DRAIN.
REQ-031 S_DRAIN SHALL wait for outstanding==0, then pulse job_done and go to S_IDLE.
REQ-032 The minimum gap from rd_ack to the next rd SHALL be 2 cycles (S_NEXT, S_CALC).
REQ-033 outstanding SHALL increment on rd_ack and decrement on tag_done; both in the same cycle SHALL leave it unchanged.
REQ-034 tag_done with outstanding==0 SHALL set err and leave the count at 0 (no wrap).
REQ-035 On rd_ack, rd_qw SHALL be written to table[rd_tag] and busy[rd_tag] set.
REQ-036 rd_ack for a tag with busy=1 SHALL set err; the table SHALL still be written.
REQ-037 On tag_done, busy[tag_done_id] SHALL be cleared; if it was already clear, err SHALL be set.
REQ-038 tag_lkp_qw SHALL equal table[tag_lkp] one cycle after tag_lkp is presented.
REQ-039 job_valid outside S_IDLE SHALL be ignored, with no job_ack.
REQ-040 A cfg_max_rd_req_size change SHALL take effect at the next S_CALC.

Reset
REQ-041 While rst=1, the state SHALL be S_IDLE; rd, job_ack, job_done, err = 0; outstanding = 0; busy = 0; hst_addr, rd_qw, tag_lkp_qw = 0. The table contents SHALL be don't-care.
REQ-042 rst asserted mid-job SHALL abandon the job, and in-flight tags SHALL be forgotten.
REQ-043 The first rd after rst deassertion SHALL occur no earlier than 2 cycles after a job_ack.

Configuration
REQ-044 Macro IBUF_RD_4K_SPLIT_EN, when defined, SHALL enable the 4KB-boundary term of REQ-024.
REQ-045 When IBUF_RD_4K_SPLIT_EN is undefined, rd_qw SHALL be min(remain, MRRS QW) only; the host driver then guarantees that jobs never cross 4KB.

Verification
REQ-046 MRRS=2, job addr 0x1000 qw=160, immediate acks SHALL give rd_qw 64,64,32 at 0x1000, 0x1200, 0x1400, then job_done after 3 tag_done.
REQ-047 With 4K split enabled, MRRS=4, addr 0x1F80 qw=100 SHALL give rd_qw 16 at 0x1F80, then 84 at 0x2000.
REQ-048 OSRW=2, job qw=96, MRRS=0, no tag_done SHALL stop after 4 acks with rd=0 and outstanding=4; one tag_done SHALL produce the 5th rd.
REQ-049 rd_ack and tag_done in the same cycle with outstanding=3 SHALL leave outstanding=3.
REQ-050 tag_done with outstanding=0 SHALL set err=1 and keep outstanding=0; a duplicate rd_ack on a busy tag SHALL set err=1.
REQ-051 rst pulsed during S_REQ with outstanding=2 SHALL give rd=0 and outstanding=0 at once; a new job SHALL restart cleanly.
